// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned fetches under a two-slot credit
// limit, buffers returned words in a 2-entry queue for decode, and squashes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc
);

  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  logic [1:0]  fifo_count;
  logic        fifo_wr_ptr;
  logic        fifo_rd_ptr;
  logic [31:0] fifo_word [2];
  logic [31:0] fifo_pc [2];
  logic        inflight_wr_ptr;
  logic        inflight_rd_ptr;
  logic [31:0] inflight_pc [2];

  logic [2:0]  credit_used;
  logic        req_accept;
  logic        rsp_fire;
  logic        rsp_drop;
  logic        fifo_push;
  logic        fifo_pop;
  logic [1:0]  outstanding_nxt;
  logic [1:0]  drop_nxt;
  logic [1:0]  fifo_count_nxt;
  logic [1:0]  redirect_lsb_unused;

  assign redirect_lsb_unused = redirect_pc[1:0];

  // Every slot, whether in flight or buffered, holds one credit of the two.
  assign credit_used       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid    = !rst && !redirect_valid && (credit_used < 3'd2);
  assign imem_req_addr     = pc;
  assign req_accept        = imem_req_valid && imem_req_ready;
  assign rsp_fire          = imem_rsp_valid && (outstanding != 2'd0);
  assign rsp_drop          = rsp_fire && (drop_cnt != 2'd0);
  assign fifo_push         = rsp_fire && !rsp_drop && !redirect_valid;
  assign instruction_valid = !rst && (fifo_count != 2'd0);
  assign fifo_pop          = instruction_valid && instruction_ready;
  assign instruction       = fifo_word[fifo_rd_ptr];
  assign instruction_pc    = fifo_pc[fifo_rd_ptr];

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_accept && !rsp_fire) begin
      outstanding_nxt = outstanding + 2'd1;
    end else if (!req_accept && rsp_fire) begin
      outstanding_nxt = outstanding - 2'd1;
    end

    // Whatever is still in flight after this cycle belongs to the old path.
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      drop_nxt = outstanding_nxt;
    end else if (rsp_drop) begin
      drop_nxt = drop_cnt - 2'd1;
    end

    fifo_count_nxt = fifo_count;
    if (redirect_valid) begin
      fifo_count_nxt = 2'd0;
    end else if (fifo_push && !fifo_pop) begin
      fifo_count_nxt = fifo_count + 2'd1;
    end else if (!fifo_push && fifo_pop) begin
      fifo_count_nxt = fifo_count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= {RESET_PC[31:2], 2'b00};
      outstanding     <= 2'd0;
      drop_cnt        <= 2'd0;
      fifo_count      <= 2'd0;
      fifo_wr_ptr     <= 1'b0;
      fifo_rd_ptr     <= 1'b0;
      inflight_wr_ptr <= 1'b0;
      inflight_rd_ptr <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_nxt;
      fifo_count  <= fifo_count_nxt;

      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_accept) begin
        pc <= pc + 32'd4;
      end

      if (req_accept) begin
        inflight_wr_ptr <= ~inflight_wr_ptr;
      end
      if (rsp_fire) begin
        inflight_rd_ptr <= ~inflight_rd_ptr;
      end

      if (redirect_valid) begin
        fifo_wr_ptr <= 1'b0;
        fifo_rd_ptr <= 1'b0;
      end else begin
        if (fifo_push) begin
          fifo_wr_ptr <= ~fifo_wr_ptr;
        end
        if (fifo_pop) begin
          fifo_rd_ptr <= ~fifo_rd_ptr;
        end
      end
    end
  end

  // Payload storage carries no reset; the counters above qualify it.
  always_ff @(posedge clk) begin
    if (req_accept) begin
      inflight_pc[inflight_wr_ptr] <= pc;
    end
    if (fifo_push) begin
      fifo_word[fifo_wr_ptr] <= imem_rsp_data;
      fifo_pc[fifo_wr_ptr]   <= inflight_pc[inflight_rd_ptr];
    end
  end

endmodule
